cfglut_n: RTL and testbench

CFGLUT_N -- requirements
Module: cfglut_n

---
 rtl/cfglut_n.sv | 95 +++++++++
 tb/tb_cfglut_n.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cfglut_n.sv
// cfglut_n -- reconfigurable K-input look-up table with a serial
// configuration chain.
//
// The 2^K-bit truth table is loaded from INIT at reset and can be replaced
// at run time by shifting new contents in through CDI, MSB first. The table
// MSB is always visible on CDO, so several blocks can be daisy-chained.
//
// Parameters
//   K     LUT input count (2..8)
//   INIT  truth table loaded at reset, 2^K bits
//   OREG  0: O5/O6 combinational, 1: O5/O6 registered (one cycle latency)
//
// Ports
//   CLK       clock, rising edge active
//   RST_N     asynchronous active-low reset
//   CE        shift enable for the configuration chain
//   CDI       serial configuration data in
//   I         LUT address, K bits
//   O6        K-input lookup, mem[I]
//   O5        (K-1)-input lookup from the lower half of the table (I[K-1] ignored)
//   CDO       serial configuration data out, table MSB
//   CFG_DONE  one-cycle pulse after every 2^K-th shift
module cfglut_n #(
  parameter int unsigned         K    = 5,
  parameter logic [(1<<K)-1:0]   INIT = '0,
  parameter bit                  OREG = 1'b0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         CE,
  input  logic         CDI,
  input  logic [K-1:0] I,
  output logic         O6,
  output logic         O5,
  output logic         CDO,
  output logic         CFG_DONE
);

  localparam int unsigned N = 1 << K;
  localparam logic [K:0]  CNT_LAST = {1'b0, {K{1'b1}}};

  logic [N-1:0]   mem;
  logic [N/2-1:0] mem_lo;
  logic [K:0]     cnt;
  logic           done_q;
  logic           lut6;
  logic           lut5;

  // Configuration chain and reload counter. The counter survives CE-low
  // gaps, so the done pulse marks the 2^K-th shift since reset or last wrap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem    <= INIT;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= CE && (cnt == CNT_LAST);
      if (CE) begin
        mem <= {mem[N-2:0], CDI};
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + (K+1)'(1);
      end
    end
  end

  assign mem_lo   = mem[N/2-1:0];
  assign lut6     = mem[I];
  assign lut5     = mem_lo[I[K-2:0]];
  assign CDO      = mem[N-1];
  assign CFG_DONE = done_q;

  generate
    if (OREG) begin : g_oreg
      logic o6_q;
      logic o5_q;

      // Captures the lookup on pre-edge table and address, regardless of CE.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          o6_q <= 1'b0;
          o5_q <= 1'b0;
        end else begin
          o6_q <= lut6;
          o5_q <= lut5;
        end
      end

      assign O6 = o6_q;
      assign O5 = o5_q;
    end else begin : g_comb
      assign O6 = lut6;
      assign O5 = lut5;
    end
  endgenerate

endmodule

// File: tb/tb_cfglut_n.sv
// tb_cfglut_n -- self-checking bench for cfglut_n.
//
// Three instances share CE/CDI/RST_N: a (K=4, combinational), b (K=4,
// registered outputs) and c (K=6, combinational, own address). A behavioural
// model tracks each table as a plain vector plus a shift tally and is
// compared against every output on each falling clock edge; directed
// sequences add hand-computed literal expectations.
module tb_cfglut_n;

  localparam logic [15:0] INIT4 = 16'hA5C3;
  localparam logic [63:0] INIT6 = 64'h0FED_CBA9_8765_4321;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       ce    = 1'b0;
  logic       cdi   = 1'b0;
  logic [3:0] i4    = '0;
  logic [5:0] i6    = '0;

  logic o6a, o5a, cdoa, donea;
  logic o6b, o5b, cdob, doneb;
  logic o6c, o5c, cdoc, donec;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  cfglut_n #(.K(4), .INIT(INIT4), .OREG(1'b0)) dut_a (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .CDI(cdi), .I(i4),
    .O6(o6a), .O5(o5a), .CDO(cdoa), .CFG_DONE(donea)
  );

  cfglut_n #(.K(4), .INIT(INIT4), .OREG(1'b1)) dut_b (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .CDI(cdi), .I(i4),
    .O6(o6b), .O5(o5b), .CDO(cdob), .CFG_DONE(doneb)
  );

  cfglut_n #(.K(6), .INIT(INIT6), .OREG(1'b0)) dut_c (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .CDI(cdi), .I(i6),
    .O6(o6c), .O5(o5c), .CDO(cdoc), .CFG_DONE(donec)
  );

  // ---------------- behavioural model ----------------
  logic [15:0] m4;
  logic [63:0] m6;
  int          n4, n6;      // shifts since reset or last completed reload
  logic        d4, d6;      // expected done pulses
  logic        e6b, e5b;    // expected registered outputs of instance b

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4  <= INIT4;
      m6  <= INIT6;
      n4  <= 0;
      n6  <= 0;
      d4  <= 1'b0;
      d6  <= 1'b0;
      e6b <= 1'b0;
      e5b <= 1'b0;
    end else begin
      e6b <= m4[i4];
      e5b <= m4[i4 % 8];
      d4  <= ce && (n4 == 15);
      d6  <= ce && (n6 == 63);
      if (ce) begin
        m4 <= {m4[14:0], cdi};
        m6 <= {m6[62:0], cdi};
        n4 <= (n4 + 1) % 16;
        n6 <= (n6 + 1) % 64;
      end
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0b expected=%0b", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("a_o6",   o6a,   m4[i4]);
      chk("a_o5",   o5a,   m4[i4 % 8]);
      chk("a_cdo",  cdoa,  m4[15]);
      chk("a_done", donea, d4);
      chk("b_o6",   o6b,   e6b);
      chk("b_o5",   o5b,   e5b);
      chk("b_cdo",  cdob,  m4[15]);
      chk("b_done", doneb, d4);
      chk("c_o6",   o6c,   m6[i6]);
      chk("c_o5",   o5c,   m6[i6 % 32]);
      chk("c_cdo",  cdoc,  m6[63]);
      chk("c_done", donec, d6);
    end
  end

  // ---------------- stimulus ----------------
  // Apply inputs, let one rising edge see them, return 2 time units later.
  task automatic step(input logic c, input logic d);
    ce  = c;
    cdi = d;
    @(posedge clk);
    #2;
  endtask

  logic [15:0] pat;
  logic [31:0] sh;
  logic [63:0] init6v;

  initial begin
    pat    = 16'h1234;
    sh     = {INIT4, 16'h1234};
    init6v = INIT6;

    // reset, with values checked while still held
    #1 rst_n = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("rst_a_o6",  o6a,   1'b1);
    chk("rst_a_o5",  o5a,   1'b1);
    chk("rst_a_cdo", cdoa,  1'b1);
    chk("rst_done",  donea, 1'b0);
    chk("rst_b_o6",  o6b,   1'b0);
    chk("rst_b_o5",  o5b,   1'b0);
    step(1'b1, 1'b0);                 // CE edge under reset has no effect
    chk("rst_prio_cdo", cdoa, 1'b1);
    chk("rst_b_o6_hold", o6b, 1'b0);
    ce = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0);

    // static lookup, K=4
    i4 = 4'd0;  #1; chk("lk0_o6", o6a, 1'b1);  chk("lk0_o5", o5a, 1'b1);
    i4 = 4'd12; #1; chk("lk12_o6", o6a, 1'b0); chk("lk12_o5", o5a, 1'b0);
    i4 = 4'd15; #1; chk("lk15_o6", o6a, 1'b1); chk("lk15_o5", o5a, 1'b1);
    chk("lk_cdo", cdoa, 1'b1);

    // registered outputs: one edge of latency
    i4 = 4'd0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("oreg_i0", o6b, 1'b1);
    i4 = 4'd12; #1;
    chk("oreg_pre_edge", o6b, 1'b1);
    step(1'b0, 1'b0);
    chk("oreg_post_edge", o6b, 1'b0);

    // exhaustive K=6 sweep
    for (int k = 0; k < 64; k++) begin
      i6 = 6'(k); #1;
      chk("k6_o6", o6c, init6v[k]);
      chk("k6_o5", o5c, init6v[k % 32]);
    end

    // full reload, contiguous CE
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, pat[16-k]);
      chk("reload_cdo", cdoa, sh[31-k]);
      chk("reload_done", donea, (k == 16));
    end
    step(1'b0, 1'b0);
    chk("reload_done_clear", donea, 1'b0);
    i4 = 4'd2; #1; chk("reload_i2", o6a, pat[2]);
    i4 = 4'd4; #1; chk("reload_i4", o6a, pat[4]);

    // reload with a CE gap after shift 5
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, pat[16-k]);
      chk("gap_done", donea, (k == 16));
      if (k == 5) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b1);
          chk("gap_idle_done", donea, 1'b0);
        end
      end
    end
    ce = 1'b0;
    for (int k = 0; k < 16; k++) begin
      i4 = 4'(k); #1;
      chk("gap_mem", o6a, pat[k]);
    end

    // reset mid-reload discards partial shifts
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0);
    ce = 1'b0;
    i4 = 4'd0;
    rst_n = 1'b0; #1;
    chk("mid_rst_o6", o6a, 1'b1);
    chk("mid_rst_cdo", cdoa, 1'b1);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'($urandom));
      chk("mid_rst_done", donea, (k == 16));
    end
    step(1'b0, 1'b0);

    // randomized traffic, checked by the model each cycle
    for (int k = 0; k < 800; k++) begin
      i4 = 4'($urandom);
      i6 = 6'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step(($urandom_range(0, 3) != 0), 1'($urandom));
    end

    ce = 1'b0;
    @(negedge clk);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
